// File: rtl/gate_pkg.sv
// Shared definitions for the gate identifier: classification codes,
// reference truth tables (indexed as truth[{a,b}] = y) and FSM encoding.
package gate_pkg;

  localparam int unsigned GATE_ID_W = 3;
  localparam int unsigned TT_W      = 4;

  localparam logic [GATE_ID_W-1:0] GATE_UNKNOWN = 3'd0;
  localparam logic [GATE_ID_W-1:0] GATE_AND     = 3'd1;
  localparam logic [GATE_ID_W-1:0] GATE_NAND    = 3'd2;
  localparam logic [GATE_ID_W-1:0] GATE_OR      = 3'd3;
  localparam logic [GATE_ID_W-1:0] GATE_NOR     = 3'd4;
  localparam logic [GATE_ID_W-1:0] GATE_NOT_A   = 3'd5;
  localparam logic [GATE_ID_W-1:0] GATE_XOR     = 3'd6;
  localparam logic [GATE_ID_W-1:0] GATE_XNOR    = 3'd7;

  localparam logic [TT_W-1:0] TT_AND   = 4'b1000;
  localparam logic [TT_W-1:0] TT_NAND  = 4'b0111;
  localparam logic [TT_W-1:0] TT_OR    = 4'b1110;
  localparam logic [TT_W-1:0] TT_NOR   = 4'b0001;
  localparam logic [TT_W-1:0] TT_NOT_A = 4'b0011;
  localparam logic [TT_W-1:0] TT_XOR   = 4'b0110;
  localparam logic [TT_W-1:0] TT_XNOR  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/gate_decode.sv
// Combinational truth-table classifier.
//   truth_i    : 4-bit table, truth_i[{a,b}] = y
//   mismatch_i : passes disagreed; forces UNKNOWN
//   gate_id_o  : classification code from gate_pkg
module gate_decode
  import gate_pkg::*;
(
  input  logic [TT_W-1:0]      truth_i,
  input  logic                 mismatch_i,
  output logic [GATE_ID_W-1:0] gate_id_o
);

  always_comb begin
    gate_id_o = GATE_UNKNOWN;
    if (!mismatch_i) begin
      case (truth_i)
        TT_AND:   gate_id_o = GATE_AND;
        TT_NAND:  gate_id_o = GATE_NAND;
        TT_OR:    gate_id_o = GATE_OR;
        TT_NOR:   gate_id_o = GATE_NOR;
        TT_NOT_A: gate_id_o = GATE_NOT_A;
        TT_XOR:   gate_id_o = GATE_XOR;
        TT_XNOR:  gate_id_o = GATE_XNOR;
        default:  gate_id_o = GATE_UNKNOWN;
      endcase
    end
  end

endmodule

// File: rtl/gate_identifier.sv
// Drives a 2-input gate under test through all input combinations, builds its
// truth table over NUM_PASSES sweeps and classifies it.
//   clk, rst          : clock, async active-high reset
//   start             : run request, honoured only in IDLE
//   probe_a/probe_b   : registered GUT inputs; probe_y: GUT output
//   busy, done        : run in progress / one-cycle results-valid pulse
//   truth, gate_id    : first-pass table and its classification
//   mismatch          : a later pass disagreed with the first
module gate_identifier
  import gate_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_PASSES    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 probe_a,
  output logic                 probe_b,
  input  logic                 probe_y,
  output logic                 busy,
  output logic                 done,
  output logic [TT_W-1:0]      truth,
  output logic [GATE_ID_W-1:0] gate_id,
  output logic                 mismatch
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned PW = $clog2(NUM_PASSES + 1);

  state_e                 state_q;
  logic [1:0]             combo_q;
  logic [PW-1:0]          pass_q;
  logic [SW-1:0]          settle_q;
  logic [TT_W-1:0]        work_q;
  logic                   mm_work_q;
  logic                   probe_a_q, probe_b_q, busy_q, done_q, mismatch_q;
  logic [TT_W-1:0]        truth_q;
  logic [GATE_ID_W-1:0]   gate_id_q;

  logic [TT_W-1:0]        work_d;
  logic                   mm_work_d;
  logic [GATE_ID_W-1:0]   gate_id_d;
  logic                   last_pass_c;

  // Table and mismatch flag as they stand after this edge's capture, so the
  // final capture of a run is included when results load on entry to DONE.
  always_comb begin
    work_d    = work_q;
    mm_work_d = mm_work_q;
    if (pass_q == '0) begin
      work_d[combo_q] = probe_y;
    end else if (probe_y != work_q[combo_q]) begin
      mm_work_d = 1'b1;
    end
  end

  assign last_pass_c = (pass_q == PW'(NUM_PASSES - 1));

  gate_decode u_decode (
    .truth_i    (work_d),
    .mismatch_i (mm_work_d),
    .gate_id_o  (gate_id_d)
  );

  // Run sequencer: settle window per combo, combo/pass stepping, result load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      combo_q    <= 2'd0;
      pass_q     <= '0;
      settle_q   <= '0;
      work_q     <= '0;
      mm_work_q  <= 1'b0;
      probe_a_q  <= 1'b0;
      probe_b_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      truth_q    <= '0;
      gate_id_q  <= GATE_UNKNOWN;
      mismatch_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_RUN;
            busy_q    <= 1'b1;
            combo_q   <= 2'd0;
            pass_q    <= '0;
            probe_a_q <= 1'b0;
            probe_b_q <= 1'b0;
            settle_q  <= SW'(SETTLE_CYCLES - 1);
            mm_work_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (settle_q != '0) begin
            settle_q <= settle_q - SW'(1);
          end else begin
            // Last edge of the window: capture and step to the next combo.
            work_q                 <= work_d;
            mm_work_q              <= mm_work_d;
            settle_q               <= SW'(SETTLE_CYCLES - 1);
            combo_q                <= combo_q + 2'd1;
            {probe_a_q, probe_b_q} <= combo_q + 2'd1;
            if (combo_q == 2'd3) begin
              if (last_pass_c) begin
                state_q    <= ST_DONE;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                truth_q    <= work_d;
                mismatch_q <= mm_work_d;
                gate_id_q  <= gate_id_d;
              end else begin
                pass_q <= pass_q + PW'(1);
              end
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign probe_a  = probe_a_q;
  assign probe_b  = probe_b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign truth    = truth_q;
  assign gate_id  = gate_id_q;
  assign mismatch = mismatch_q;

endmodule

// File: tb/tb_gate_identifier.sv
// Directed bench for gate_identifier: a default instance (2 settle, 2 passes)
// and a minimal instance (1 settle, 1 pass), each probing a table-driven GUT.
module tb_gate_identifier;

  logic clk = 1'b0;
  logic rst, start, start1;
  logic pa, pb, py, busy, done, mm;
  logic [3:0] truth;
  logic [2:0] gid;
  logic pa1, pb1, py1, busy1, done1, mm1;
  logic [3:0] truth1;
  logic [2:0] gid1;
  logic [3:0] gut_tt, gut_tt1;
  logic flip;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // GUT models: truth-table lookup, optional corruption of combo 01.
  assign py  = gut_tt[{pa, pb}] ^ (flip && ({pa, pb} == 2'b01));
  assign py1 = gut_tt1[{pa1, pb1}];

  gate_identifier #(.SETTLE_CYCLES(2), .NUM_PASSES(2)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .probe_a(pa), .probe_b(pb), .probe_y(py),
    .busy(busy), .done(done), .truth(truth), .gate_id(gid), .mismatch(mm)
  );

  gate_identifier #(.SETTLE_CYCLES(1), .NUM_PASSES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .probe_a(pa1), .probe_b(pb1), .probe_y(py1),
    .busy(busy1), .done(done1), .truth(truth1), .gate_id(gid1), .mismatch(mm1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, return the edge count (after accept) of the first done, or -1.
  task automatic run0(output int done_at);
    done_at = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done === 1'b1) begin
        done_at = k;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    gut_tt = 4'b0000; gut_tt1 = 4'b0000; flip = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if ({pa, pb} !== 2'b00) begin failures++; $display("FAIL reset_probes got=%b exp=00", {pa, pb}); end
    checks++; if (truth !== 4'b0000) begin failures++; $display("FAIL reset_truth got=%b exp=0000", truth); end
    checks++; if (gid !== 3'd0) begin failures++; $display("FAIL reset_gate_id got=%0d exp=0", gid); end
    checks++; if (mm !== 1'b0) begin failures++; $display("FAIL reset_mismatch got=%b exp=0", mm); end
    checks++; if ({busy1, done1, truth1, gid1} !== 9'd0) begin failures++; $display("FAIL reset_dut1 got=%b exp=0", {busy1, done1, truth1, gid1}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_and_sweep();
    logic [1:0] exp_combo;
    gut_tt = 4'b1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL and_busy_accept got=%b exp=1", busy); end
    checks++; if ({pa, pb} !== 2'b00) begin failures++; $display("FAIL and_probe_accept got=%b exp=00", {pa, pb}); end
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k < 16) begin
        exp_combo = 2'((k / 2) % 4);
        checks++; if ({pa, pb} !== exp_combo) begin failures++; $display("FAIL and_probe_k%0d got=%b exp=%b", k, {pa, pb}, exp_combo); end
        checks++; if ({busy, done} !== 2'b10) begin failures++; $display("FAIL and_busydone_k%0d got=%b exp=10", k, {busy, done}); end
      end
    end
    checks++; if ({busy, done} !== 2'b01) begin failures++; $display("FAIL and_done_edge16 got=%b exp=01", {busy, done}); end
    checks++; if ({pa, pb} !== 2'b00) begin failures++; $display("FAIL and_probe_done got=%b exp=00", {pa, pb}); end
    checks++; if (truth !== 4'b1000) begin failures++; $display("FAIL and_truth got=%b exp=1000", truth); end
    checks++; if (gid !== 3'd1) begin failures++; $display("FAIL and_gate_id got=%0d exp=1", gid); end
    checks++; if (mm !== 1'b0) begin failures++; $display("FAIL and_mismatch got=%b exp=0", mm); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL and_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_all_gates();
    logic [3:0] tts [8];
    logic [2:0] ids [8];
    int d;
    tts = '{4'b1000, 4'b0111, 4'b1110, 4'b0001, 4'b0011, 4'b0110, 4'b1001, 4'b1111};
    ids = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    for (int i = 0; i < 8; i++) begin
      gut_tt = tts[i];
      run0(d);
      checks++; if (d != 16) begin failures++; $display("FAIL gates_latency_%0d got=%0d exp=16", i, d); end
      checks++; if (truth !== tts[i]) begin failures++; $display("FAIL gates_truth_%0d got=%b exp=%b", i, truth, tts[i]); end
      checks++; if (gid !== ids[i]) begin failures++; $display("FAIL gates_id_%0d got=%0d exp=%0d", i, gid, ids[i]); end
      checks++; if (mm !== 1'b0) begin failures++; $display("FAIL gates_mismatch_%0d got=%b exp=0", i, mm); end
    end
  endtask

  task automatic test_mismatch();
    int d;
    gut_tt = 4'b0110;
    flip = 1'b0;
    d = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 8) flip = 1'b1;
      if (done === 1'b1) begin
        d = k;
        break;
      end
    end
    flip = 1'b0;
    checks++; if (d != 16) begin failures++; $display("FAIL mm_latency got=%0d exp=16", d); end
    checks++; if (truth !== 4'b0110) begin failures++; $display("FAIL mm_truth got=%b exp=0110", truth); end
    checks++; if (mm !== 1'b1) begin failures++; $display("FAIL mm_flag got=%b exp=1", mm); end
    checks++; if (gid !== 3'd0) begin failures++; $display("FAIL mm_gate_id got=%0d exp=0", gid); end
    tick();
  endtask

  task automatic test_start_ignored();
    int dones, first, d2;
    gut_tt = 4'b1001;
    dones = 0; first = -1; d2 = -1;
    start = 1'b1;
    tick();
    for (int k = 1; k <= 30; k++) begin
      start = (k == 3 || k == 10);
      tick();
      if (done === 1'b1) begin
        dones++;
        if (first < 0) first = k;
      end
    end
    start = 1'b0;
    checks++; if (dones != 1) begin failures++; $display("FAIL restart_done_count got=%0d exp=1", dones); end
    checks++; if (first != 16) begin failures++; $display("FAIL restart_latency got=%0d exp=16", first); end
    checks++; if (gid !== 3'd7) begin failures++; $display("FAIL restart_gate_id got=%0d exp=7", gid); end
    // Start held high: next run accepted in the IDLE cycle following DONE.
    first = -1;
    start = 1'b1;
    tick();
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (done === 1'b1 && first < 0) first = k;
    end
    checks++; if (first != 16) begin failures++; $display("FAIL held_latency got=%0d exp=16", first); end
    tick();
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL held_idle got=%b exp=00", {busy, done}); end
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL held_reaccept got=%b exp=1", busy); end
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done === 1'b1) begin
        d2 = k;
        break;
      end
    end
    checks++; if (d2 != 16) begin failures++; $display("FAIL held_second_run got=%0d exp=16", d2); end
    tick();
  endtask

  task automatic test_reset_midrun();
    int d;
    gut_tt = 4'b0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({busy, done, pa, pb, mm} !== 5'd0) begin failures++; $display("FAIL rstmid_ctrl got=%b exp=00000", {busy, done, pa, pb, mm}); end
    checks++; if (truth !== 4'b0000) begin failures++; $display("FAIL rstmid_truth got=%b exp=0000", truth); end
    checks++; if (gid !== 3'd0) begin failures++; $display("FAIL rstmid_gate_id got=%0d exp=0", gid); end
    @(negedge clk);
    rst = 1'b0;
    run0(d);
    checks++; if (d != 16) begin failures++; $display("FAIL rstmid_rerun_latency got=%0d exp=16", d); end
    checks++; if (truth !== 4'b0001) begin failures++; $display("FAIL rstmid_rerun_truth got=%b exp=0001", truth); end
    checks++; if (gid !== 3'd4) begin failures++; $display("FAIL rstmid_rerun_gate_id got=%0d exp=4", gid); end
  endtask

  task automatic test_small_params();
    int d;
    d = -1;
    gut_tt1 = 4'b0011;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done1 === 1'b1) begin
        d = k;
        break;
      end
    end
    checks++; if (d != 4) begin failures++; $display("FAIL small_latency got=%0d exp=4", d); end
    checks++; if (truth1 !== 4'b0011) begin failures++; $display("FAIL small_truth got=%b exp=0011", truth1); end
    checks++; if (gid1 !== 3'd5) begin failures++; $display("FAIL small_gate_id got=%0d exp=5", gid1); end
    checks++; if (mm1 !== 1'b0) begin failures++; $display("FAIL small_mismatch got=%b exp=0", mm1); end
    tick();
  endtask

  initial begin
    test_reset();
    test_and_sweep();
    test_all_gates();
    test_mismatch();
    test_start_ignored();
    test_reset_midrun();
    test_small_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
